// File: rtl/kmeans_pkg.sv
// kmeans_pkg
// Shared constants for the kMeans data-SRAM slice: SRAM geometry, number of
// SRAM requesters and their fixed indices, plus a helper that sizes the
// binary requester-index fields.
package kmeans_pkg;

   localparam int AW        = 12;    // SRAM address width
   localparam int DW        = 16;    // SRAM word: {x[7:0], y[7:0]}
   localparam int DATA_SIZE = 4096;  // SRAM depth in words
   localparam int NUM_REQ   = 3;     // requesters sharing the SRAM

   localparam int REQ_LOAD  = 0;     // input loader (write stream)
   localparam int REQ_GROUP = 1;     // group/accumulate reader
   localparam int REQ_HOST  = 2;     // host/debug readback

   // Width of a binary index into n requesters; never narrower than 1 bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/kmeans_rr_arb.sv
// kmeans_rr_arb
// Round-robin arbiter with a per-requester burst lock.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req[N]       request per requester
//   lock[N]      keep the grant while req stays high
//   gnt[N]       one-hot grant (combinational), zero while in reset
//   gnt_idx      binary index of the granted requester (valid with accept)
//   accept       a grant is being issued this cycle
// Owns the round-robin "last granted" pointer and the lock-owner register.
module kmeans_rr_arb
   import kmeans_pkg::*;
#(
   parameter int N = kmeans_pkg::NUM_REQ,
   localparam int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  lock,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          accept
);

   logic [IW-1:0] last_reg;
   logic [IW-1:0] owner_reg;
   logic          owner_vld_reg;

   logic [IW-1:0] pick_idx;
   logic          pick_vld;

   // Selection. A live lock owner wins outright; otherwise scan the indices
   // after last_reg. The scan runs from the farthest candidate down to the
   // nearest so the nearest requesting index is the one left standing.
   always_comb begin
      int cand;
      cand     = 0;
      pick_idx = '0;
      pick_vld = 1'b0;
      if (owner_vld_reg && req[owner_reg]) begin
         pick_idx = owner_reg;
         pick_vld = 1'b1;
      end else begin
         for (int k = N; k >= 1; k--) begin
            cand = int'(last_reg) + k;
            if (cand >= N) begin
               cand = cand - N;
            end
            if (req[IW'(cand)]) begin
               pick_idx = IW'(cand);
               pick_vld = 1'b1;
            end
         end
      end
      if (!rst_n) begin
         pick_vld = 1'b0;
      end
   end

   always_comb begin
      gnt = '0;
      if (pick_vld) begin
         gnt[pick_idx] = 1'b1;
      end
   end

   assign gnt_idx = pick_idx;
   assign accept  = pick_vld;

   // A grant is only issued to a requesting index, so "no grant" also means
   // the lock owner has dropped req: the lock is released in that case.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_reg      <= IW'(N - 1);
         owner_reg     <= '0;
         owner_vld_reg <= 1'b0;
      end else if (pick_vld) begin
         last_reg      <= pick_idx;
         owner_reg     <= pick_idx;
         owner_vld_reg <= lock[pick_idx];
      end else begin
         owner_vld_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/kmeans_sram_arbiter.sv
// kmeans_sram_arbiter
// Shares the single-port data SRAM between NUM_REQ requesters (loader,
// grouper, host). One SRAM access per cycle, round-robin with burst lock;
// read data returns in order with a one-hot rvalid naming its requester.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req/we/lock[NUM_REQ] per-requester request, write enable, burst lock
//   addr, wdata         packed per-requester address / write data
//   gnt                 one-hot combinational grant
//   rvalid, rdata       registered read return (rdata shared, held when idle)
//   busy                registered, high while any read is in flight
//   mem_a/mem_di/mem_web  registered SRAM address, write data, write enable (low)
//   mem_do              SRAM read data, valid one cycle after mem_a
// Read latency is 3 cycles from accept to rvalid.
module kmeans_sram_arbiter
   import kmeans_pkg::*;
#(
   parameter int NUM_REQ = kmeans_pkg::NUM_REQ,
   parameter int AW      = kmeans_pkg::AW,
   parameter int DW      = kmeans_pkg::DW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    we,
   input  logic [NUM_REQ-1:0]    lock,
   input  logic [NUM_REQ*AW-1:0] addr,
   input  logic [NUM_REQ*DW-1:0] wdata,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    rvalid,
   output logic [DW-1:0]         rdata,
   output logic                  busy,
   output logic [AW-1:0]         mem_a,
   output logic [DW-1:0]         mem_di,
   output logic                  mem_web,
   input  logic [DW-1:0]         mem_do
);

   localparam int IW = idx_width(NUM_REQ);

   logic [AW-1:0] addr_arr  [NUM_REQ];
   logic [DW-1:0] wdata_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = addr[gi*AW +: AW];
         assign wdata_arr[gi] = wdata[gi*DW +: DW];
      end
   endgenerate

   logic [IW-1:0] gnt_idx;
   logic          accept;
   logic          read_acc;

   kmeans_rr_arb #(
      .N (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .lock    (lock),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .accept  (accept)
   );

   assign read_acc = accept & ~we[gnt_idx];

   logic [AW-1:0]      mem_a_reg;
   logic [DW-1:0]      mem_di_reg;
   logic               mem_web_reg;
   // Tag pipe: stage 0 follows the SRAM address cycle, stage 1 lines up
   // with mem_do being valid.
   logic               tag0_vld_reg;
   logic [IW-1:0]      tag0_idx_reg;
   logic               tag1_vld_reg;
   logic [IW-1:0]      tag1_idx_reg;
   logic [NUM_REQ-1:0] rvalid_reg;
   logic [NUM_REQ-1:0] rvalid_next;
   logic [DW-1:0]      rdata_reg;
   logic               busy_reg;

   always_comb begin
      rvalid_next = '0;
      if (tag1_vld_reg) begin
         rvalid_next[tag1_idx_reg] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_a_reg    <= '0;
         mem_di_reg   <= '0;
         mem_web_reg  <= 1'b1;
         tag0_vld_reg <= 1'b0;
         tag0_idx_reg <= '0;
         tag1_vld_reg <= 1'b0;
         tag1_idx_reg <= '0;
         rvalid_reg   <= '0;
         rdata_reg    <= '0;
         busy_reg     <= 1'b0;
      end else begin
         if (accept) begin
            mem_a_reg   <= addr_arr[gnt_idx];
            mem_di_reg  <= wdata_arr[gnt_idx];
            mem_web_reg <= ~we[gnt_idx];
         end else begin
            // Idle cycle: harmless read of the held address, result dropped.
            mem_web_reg <= 1'b1;
         end
         tag0_vld_reg <= read_acc;
         tag0_idx_reg <= gnt_idx;
         tag1_vld_reg <= tag0_vld_reg;
         tag1_idx_reg <= tag0_idx_reg;
         rvalid_reg   <= rvalid_next;
         if (tag1_vld_reg) begin
            rdata_reg <= mem_do;
         end
         // Value the tag stages take after this edge.
         busy_reg     <= read_acc | tag0_vld_reg;
      end
   end

   assign mem_a   = mem_a_reg;
   assign mem_di  = mem_di_reg;
   assign mem_web = mem_web_reg;
   assign rvalid  = rvalid_reg;
   assign rdata   = rdata_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_kmeans_sram_arbiter.sv
// tb_kmeans_sram_arbiter
// Directed bench for kmeans_sram_arbiter with a behavioural 4096x16
// single-port SRAM (registered read, one-cycle latency).
module tb_kmeans_sram_arbiter;

   localparam int N  = 3;
   localparam int AW = 12;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N-1:0]    we;
   logic [N-1:0]    lock;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rvalid;
   logic [DW-1:0]   rdata;
   logic            busy;
   logic [AW-1:0]   mem_a;
   logic [DW-1:0]   mem_di;
   logic            mem_web;
   logic [DW-1:0]   mem_do;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   kmeans_sram_arbiter #(
      .NUM_REQ (N),
      .AW      (AW),
      .DW      (DW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .we      (we),
      .lock    (lock),
      .addr    (addr),
      .wdata   (wdata),
      .gnt     (gnt),
      .rvalid  (rvalid),
      .rdata   (rdata),
      .busy    (busy),
      .mem_a   (mem_a),
      .mem_di  (mem_di),
      .mem_web (mem_web),
      .mem_do  (mem_do)
   );

   // SRAM model
   logic [DW-1:0] sram [4096];
   always @(posedge clk) begin
      if (!mem_web) begin
         sram[mem_a] <= mem_di;
      end
      mem_do <= sram[mem_a];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
         $display("check %s: observed=%0h expected=%0h ok", tag, obs, exp);
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      addr[i*AW +: AW] = a;
   endtask

   task automatic set_wdata(input int i, input logic [DW-1:0] d);
      wdata[i*DW +: DW] = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  exp_seq [6];
      logic [11:0] ea;
      logic [15:0] ed;
      int gerr, rverr, rcnt, rerr, first_c, last_c;

      exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

      // ---------------- reset with all requesters asserting
      rst_n = 1'b0;
      req   = 3'b111;
      we    = '0;
      lock  = '0;
      addr  = '0;
      wdata = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_gnt", 32'(gnt), 32'h0);
      end
      check("reset_rvalid",  32'(rvalid),  32'h0);
      check("reset_mem_web", 32'(mem_web), 32'h1);
      check("reset_rdata",   32'(rdata),   32'h0);
      check("reset_busy",    32'(busy),    32'h0);
      next_cycle();
      rst_n = 1'b1;
      req   = '0;
      next_cycle();

      // ---------------- write 0x005 <- 0xA1B2 then read it back
      req = 3'b001; we = 3'b001;
      set_addr(0, 12'h005); set_wdata(0, 16'hA1B2);
      @(negedge clk);
      check("wr_gnt", 32'(gnt), 32'h1);
      next_cycle();
      req = 3'b010; we = 3'b000;
      set_addr(1, 12'h005);
      @(negedge clk);
      check("rd_gnt",     32'(gnt),     32'h2);
      check("wr_mem_web", 32'(mem_web), 32'h0);
      check("wr_mem_a",   32'(mem_a),   32'h005);
      check("wr_mem_di",  32'(mem_di),  32'hA1B2);
      next_cycle();
      req = '0;
      @(negedge clk);
      check("rd_t1_rvalid",  32'(rvalid),  32'h0);
      check("rd_t1_mem_web", 32'(mem_web), 32'h1);
      check("rd_t1_mem_a",   32'(mem_a),   32'h005);
      check("rd_t1_busy",    32'(busy),    32'h1);
      next_cycle();
      @(negedge clk);
      check("rd_t2_rvalid", 32'(rvalid), 32'h0);
      next_cycle();
      @(negedge clk);
      check("rd_t3_rvalid", 32'(rvalid), 32'h2);
      check("rd_t3_rdata",  32'(rdata),  32'hA1B2);
      next_cycle();
      @(negedge clk);
      check("rd_t4_rvalid", 32'(rvalid), 32'h0);
      check("rd_t4_rdata",  32'(rdata),  32'hA1B2);
      next_cycle();

      // ---------------- contention without lock (host first moves last to 2)
      req = 3'b100;
      next_cycle();
      req = 3'b111;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("rr_gnt_%0d", i), 32'(gnt), 32'(exp_seq[i]));
         next_cycle();
      end

      // ---------------- lock: loader first moves last to 0
      req = 3'b001;
      next_cycle();
      req  = 3'b111;
      lock = 3'b010;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("lock_gnt_%0d", i), 32'(gnt), 32'h2);
         next_cycle();
      end
      // grouper drops req; its lock bit alone must not hold the grant
      req = 3'b101;
      @(negedge clk);
      check("unlock_gnt_host", 32'(gnt), 32'h4);
      next_cycle();
      @(negedge clk);
      check("unlock_gnt_load", 32'(gnt), 32'h1);
      next_cycle();
      req  = '0;
      lock = '0;
      for (int i = 0; i < 5; i++) next_cycle();

      // ---------------- load 4096 words x=addr[11:4], y=addr[7:0]
      gerr  = 0;
      rverr = 0;
      req = 3'b001; we = 3'b001;
      for (int a = 0; a < 4096; a++) begin
         ea = 12'(a);
         set_addr(0, ea);
         set_wdata(0, {ea[11:4], ea[7:0]});
         @(negedge clk);
         if (gnt !== 3'b001) gerr++;
         if (rvalid !== 3'b000) rverr++;
         next_cycle();
      end
      req = '0; we = '0;
      check("load_gnt_errors",  32'(gerr),  32'h0);
      check("load_rvalid_seen", 32'(rverr), 32'h0);
      next_cycle();

      // ---------------- stream read 0..4095 by the grouper
      gerr    = 0;
      rcnt    = 0;
      rerr    = 0;
      first_c = -1;
      last_c  = -1;
      for (int c = 0; c < 4106; c++) begin
         if (c < 4096) begin
            req = 3'b010;
            set_addr(1, 12'(c));
         end else begin
            req = '0;
         end
         @(negedge clk);
         if (c < 4096 && gnt !== 3'b010) gerr++;
         if (rvalid !== 3'b000) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            ea = 12'(rcnt);
            ed = {ea[11:4], ea[7:0]};
            if (rvalid !== 3'b010 || rdata !== ed) rerr++;
            rcnt++;
         end
         next_cycle();
      end
      check("stream_gnt_errors", 32'(gerr),            32'h0);
      check("stream_count",      32'(rcnt),            32'd4096);
      check("stream_first",      32'(first_c),         32'd3);
      check("stream_span",       32'(last_c - first_c), 32'd4095);
      check("stream_data_err",   32'(rerr),            32'h0);

      // ---------------- reset with two reads in flight
      req = 3'b010; we = '0;
      set_addr(1, 12'h007);
      next_cycle();
      set_addr(1, 12'h008);
      next_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy_before", 32'(busy), 32'h1);
      check("midrst_gnt",         32'(gnt),  32'h0);
      next_cycle();
      rst_n = 1'b1;
      req   = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("midrst_rvalid_%0d", i),  32'(rvalid),  32'h0);
         check($sformatf("midrst_busy_%0d", i),    32'(busy),    32'h0);
         check($sformatf("midrst_mem_web_%0d", i), 32'(mem_web), 32'h1);
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
